// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: clips a command to the visible area and streams one framebuffer write per clock, row-major.
// Latency: first write on the cycle after command acceptance; done_o pulses on the cycle after the last write (or right after accepting an empty command).
// Backpressure: the framebuffer port never stalls; cmd_ready_o is low for the whole fill, so the command handshake is the only flow control.
//
// Ports:
//   clk, rst                 sole clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o  command handshake
//   cmd_x_i, cmd_y_i         top-left corner (column, line)
//   cmd_w_i, cmd_h_i         size in pixels / lines (zero is legal)
//   cmd_color_i              fill word
//   wr_en_o/wr_addr_o/wr_data_o  framebuffer write port (address = y*VGA_WIDTH + x)
//   busy_o                   high while filling
//   done_o                   one-cycle completion pulse
module vga_rect_fill #(
  parameter int VGA_WIDTH  = 640,
  parameter int VGA_HEIGHT = 480,
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [9:0]            cmd_x_i,
  input  logic [9:0]            cmd_y_i,
  input  logic [9:0]            cmd_w_i,
  input  logic [9:0]            cmd_h_i,
  input  logic [DATA_WIDTH-1:0] cmd_color_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  localparam logic [10:0]           W11      = 11'(VGA_WIDTH);
  localparam logic [10:0]           H11      = 11'(VGA_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(VGA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [0:0]            state_q;
  logic [10:0]           col_q;
  logic [10:0]           row_q;
  logic [10:0]           w_q;
  logic [10:0]           h_q;
  // Address of the first pixel of the row currently being written.
  logic [ADDR_WIDTH-1:0] row_base_q;

  logic [10:0]           x_ext;
  logic [10:0]           y_ext;
  logic [10:0]           w_ext;
  logic [10:0]           h_ext;
  logic [10:0]           clip_w;
  logic [10:0]           clip_h;
  logic                  clip_empty;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  last_col;
  logic                  last_row;

  // Clipping in 11 bits so that x+w and VGA_WIDTH-x never wrap.
  always_comb begin
    x_ext  = {1'b0, cmd_x_i};
    y_ext  = {1'b0, cmd_y_i};
    w_ext  = {1'b0, cmd_w_i};
    h_ext  = {1'b0, cmd_h_i};
    clip_w = 11'd0;
    clip_h = 11'd0;
    if (x_ext < W11) begin
      clip_w = (w_ext < (W11 - x_ext)) ? w_ext : (W11 - x_ext);
    end
    if (y_ext < H11) begin
      clip_h = (h_ext < (H11 - y_ext)) ? h_ext : (H11 - y_ext);
    end
    clip_empty = (clip_w == 11'd0) || (clip_h == 11'd0);
    // The only multiply: row base computed once per accepted command.
    // Its value is irrelevant when the clipped rectangle is empty.
    start_addr = ADDR_WIDTH'(cmd_y_i) * ROW_STEP + ADDR_WIDTH'(cmd_x_i);
  end

  assign last_col = (col_q == (w_q - 11'd1));
  assign last_row = (row_q == (h_q - 11'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_ready_o <= 1'b1;
      wr_en_o     <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      col_q       <= 11'd0;
      row_q       <= 11'd0;
      w_q         <= 11'd0;
      h_q         <= 11'd0;
      row_base_q  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            if (clip_empty) begin
              done_o <= 1'b1;
            end else begin
              // First pixel is presented immediately; wr_data_o doubles
              // as the latched fill colour for the rest of the command.
              state_q     <= S_FILL;
              cmd_ready_o <= 1'b0;
              busy_o      <= 1'b1;
              wr_en_o     <= 1'b1;
              wr_addr_o   <= start_addr;
              wr_data_o   <= cmd_color_i;
              row_base_q  <= start_addr;
              col_q       <= 11'd0;
              row_q       <= 11'd0;
              w_q         <= clip_w;
              h_q         <= clip_h;
            end
          end
        end
        S_FILL: begin
          // col_q/row_q describe the pixel currently on the write port.
          if (last_col) begin
            col_q <= 11'd0;
            if (last_row) begin
              state_q     <= S_IDLE;
              cmd_ready_o <= 1'b1;
              busy_o      <= 1'b0;
              wr_en_o     <= 1'b0;
              done_o      <= 1'b1;
            end else begin
              row_q      <= row_q + 11'd1;
              row_base_q <= row_base_q + ROW_STEP;
              wr_addr_o  <= row_base_q + ROW_STEP;
            end
          end else begin
            col_q     <= col_q + 11'd1;
            wr_addr_o <= wr_addr_o + ADDR_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: directed plan plus random rectangles
// compared against a loop-based model of the clipped write sequence.
module tb_vga_rect_fill;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int AW = 19;
  localparam int DW = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [9:0]    cmd_x, cmd_y, cmd_w, cmd_h;
  logic [DW-1:0] cmd_color;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  vga_rect_fill #(
    .VGA_WIDTH(W), .VGA_HEIGHT(H), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_x_i(cmd_x), .cmd_y_i(cmd_y), .cmd_w_i(cmd_w), .cmd_h_i(cmd_h),
    .cmd_color_i(cmd_color),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .done_o(done)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  wr_t wq[$];
  int  dq[$];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample outputs 1 time unit after the edge.
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (wr_en === 1'b1) begin
      e.addr = int'(wr_addr);
      e.data = int'(wr_data);
      e.cyc  = cyc;
      wq.push_back(e);
    end
    if (done === 1'b1) dq.push_back(cyc);
  endtask

  // Scramble command inputs while the engine is busy; they must be ignored.
  task automatic drive_junk();
    if (cmd_ready === 1'b1) begin
      cmd_valid = 1'b0;
    end else begin
      cmd_valid = 1'($urandom);
      cmd_x     = 10'($urandom);
      cmd_y     = 10'($urandom);
      cmd_w     = 10'($urandom);
      cmd_h     = 10'($urandom);
      cmd_color = DW'($urandom);
    end
  endtask

  function automatic int clipped(input int pos, input int len, input int lim);
    if (pos >= lim) return 0;
    return (len < lim - pos) ? len : lim - pos;
  endfunction

  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input int color, input string tag);
    int wc, hc, n, t, bud, k;
    int exp_addr[$];
    wc = clipped(x, w, W);
    hc = clipped(y, h, H);
    n  = wc * hc;
    for (int r = 0; r < hc; r++)
      for (int c = 0; c < wc; c++)
        exp_addr.push_back((y + r) * W + x + c);

    wq.delete();
    dq.delete();
    cmd_x = 10'(x); cmd_y = 10'(y); cmd_w = 10'(w); cmd_h = 10'(h);
    cmd_color = DW'(color);
    cmd_valid = 1'b1;
    bud = 0;
    while (cmd_ready !== 1'b1 && bud < 50) begin
      step();
      bud++;
    end
    chk({tag, " ready_before"}, 64'(cmd_ready), 64'd1);
    t = cyc;
    step();
    chk({tag, " busy_first"}, 64'(busy), (n > 0) ? 64'd1 : 64'd0);
    chk({tag, " ready_first"}, 64'(cmd_ready), (n > 0) ? 64'd0 : 64'd1);
    bud = 0;
    while (dq.size() == 0 && bud < n + 5) begin
      drive_junk();
      step();
      bud++;
    end
    cmd_valid = 1'b0;
    chk({tag, " write_count"}, 64'(wq.size()), 64'(n));
    k = (wq.size() < n) ? wq.size() : n;
    for (int i = 0; i < k; i++) begin
      chk({tag, " addr"}, 64'(wq[i].addr), 64'(exp_addr[i]));
      chk({tag, " data"}, 64'(wq[i].data), 64'(color & ((1 << DW) - 1)));
      chk({tag, " write_cycle"}, 64'(wq[i].cyc), 64'(t + 1 + i));
    end
    chk({tag, " done_count"}, 64'(dq.size()), 64'd1);
    if (dq.size() > 0) chk({tag, " done_cycle"}, 64'(dq[0]), 64'(t + n + 1));
    chk({tag, " ready_at_done"}, 64'(cmd_ready), 64'd1);
    chk({tag, " wr_en_at_done"}, 64'(wr_en), 64'd0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;

    // Reset state
    repeat (3) step();
    chk("rst ready", 64'(cmd_ready), 64'd1);
    chk("rst wr_en", 64'(wr_en), 64'd0);
    chk("rst wr_addr", 64'(wr_addr), 64'd0);
    chk("rst wr_data", 64'(wr_data), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    rst = 1'b0;
    step();

    // Directed plan
    run_cmd(10, 2, 3, 2, 32'h1ABCDEF, "basic");
    run_cmd(638, 479, 5, 5, 32'h0123456, "clip_br");
    run_cmd(0, 0, 0, 4, 32'h1555555, "empty_w0");
    run_cmd(700, 0, 4, 4, 32'h0AAAAAA, "empty_x700");
    run_cmd(0, 500, 4, 4, 32'h0000001, "empty_y500");

    // Back-to-back: valid held high across two 1x1 commands
    wq.delete();
    dq.delete();
    cmd_x = 10'd0; cmd_y = 10'd0; cmd_w = 10'd1; cmd_h = 10'd1;
    cmd_color = 25'h0111111;
    cmd_valid = 1'b1;
    t = cyc;
    step();
    cmd_x = 10'd1; cmd_color = 25'h0222222;
    step();
    chk("b2b ready_at_first_done", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    cmd_x = 10'd300; cmd_color = 25'h1FFFFFF;
    step();
    chk("b2b write_count", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk("b2b addr0", 64'(wq[0].addr), 64'd0);
      chk("b2b data0", 64'(wq[0].data), 64'h0111111);
      chk("b2b cyc0", 64'(wq[0].cyc), 64'(t + 1));
      chk("b2b addr1", 64'(wq[1].addr), 64'd1);
      chk("b2b data1", 64'(wq[1].data), 64'h0222222);
      chk("b2b cyc1", 64'(wq[1].cyc), 64'(t + 3));
    end
    chk("b2b done_count", 64'(dq.size()), 64'd2);
    if (dq.size() == 2) begin
      chk("b2b done0", 64'(dq[0]), 64'(t + 2));
      chk("b2b done1", 64'(dq[1]), 64'(t + 4));
    end
    step();

    // Reset in the middle of a full-screen fill
    wq.delete();
    dq.delete();
    cmd_x = 10'd0; cmd_y = 10'd0; cmd_w = 10'd640; cmd_h = 10'd480;
    cmd_color = 25'h1234567;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int b = 0; b < 300 && wq.size() < 100; b++) step();
    chk("midrst writes_before", 64'(wq.size()), 64'd100);
    if (wq.size() > 0) chk("midrst last_addr", 64'(wq[wq.size()-1].addr), 64'(wq.size() - 1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst wr_en", 64'(wr_en), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst ready", 64'(cmd_ready), 64'd1);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst wr_addr", 64'(wr_addr), 64'd0);
    chk("midrst wr_data", 64'(wr_data), 64'd0);
    repeat (3) step();
    chk("midrst no_done", 64'(dq.size()), 64'd0);
    chk("midrst writes_total", 64'(wq.size()), 64'd100);
    run_cmd(5, 5, 1, 1, 32'h0FEDCBA, "after_rst");

    // Random rectangles, biased towards the right/bottom edges
    for (int i = 0; i < 30; i++) begin
      int x, y, w, h;
      x = ($urandom_range(0, 2) == 0) ? $urandom_range(625, 700) : $urandom_range(0, 700);
      y = ($urandom_range(0, 2) == 0) ? $urandom_range(470, 520) : $urandom_range(0, 520);
      w = $urandom_range(0, 12);
      h = $urandom_range(0, 6);
      run_cmd(x, y, w, h, int'($urandom_range(0, 32'h1FFFFFF)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
